alu_req_arbiter: RTL and testbench
==================================

Name: alu_req_arbiter

Overview:
- Two-requester controller that time-shares one combinational 8-bit ALU (operands A/B, 3-bit ALU_Sel, Result, Zero).
- Accepts operation requests over valid/ready handshakes and arbitrates them round-robin.
- Drives the ALU from registered operands, waits a programmable settle time, captures Result/Zero, and returns them on a per-requester response handshake.
- Sits between the ALU instance and its clients, for example a sequencer and a test/debug port.

Parameters:
- DATA_W, 8, operand and result width; must match the ALU.
- SEL_W, 3, ALU_Sel width.
- ALU_WAIT, 1, clock edges between operand launch and result capture; legal range 1..15.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req0_valid  input  1  requester 0 has an operation.
- req0_ready  output  1  requester 0 operation accepted this edge if valid.
- req0_a  input  DATA_W  requester 0 operand A.
- req0_b  input  DATA_W  requester 0 operand B.
- req0_sel  input  SEL_W  requester 0 ALU opcode.
- rsp0_valid  output  1  result for requester 0 available.
- rsp0_ready  input  1  requester 0 consumes result.
- rsp0_result  output  DATA_W  captured ALU Result.
- rsp0_zero  output  1  captured ALU Zero.
- req1_*, rsp1_*: identical set for requester 1.
- alu_a  output  DATA_W  to ALU A.
- alu_b  output  DATA_W  to ALU B.
- alu_sel  output  SEL_W  to ALU ALU_Sel.
- alu_result  input  DATA_W  from ALU Result.
- alu_zero  input  1  from ALU Zero.
- busy  output  1  high whenever state is not IDLE.

Behaviour:
- Single clock. Reset is asynchronous and active-low on rst_n.
- Reset values:
  - State is IDLE; priority pointer selects requester 0.
  - alu_a, alu_b, alu_sel, rsp*_result and rsp*_zero are 0.
  - rsp*_valid and busy are 0.
- States are IDLE, EXEC and RESP.
- Grant is combinational in IDLE:
  - If only one requester is valid, it is granted.
  - If both are valid, the one selected by the pointer is granted.
- reqN_ready = (state==IDLE) && grant==N. It is never high outside IDLE, and never high for both requesters at once.
- Acceptance at the edge where valid && ready:
  - req operands and sel are registered into alu_a/alu_b/alu_sel.
  - The owner ID is latched.
  - The wait counter loads ALU_WAIT-1.
  - State goes to EXEC.
  - The pointer moves to the other requester, so the served requester has lowest priority next.
- EXEC:
  - alu_* are held stable.
  - The counter decrements each edge.
  - At the edge where the counter is 0: alu_result and alu_zero are captured into the owner's rsp regs, the owner's rsp_valid is set to 1, and state goes to RESP.
- Latency: rspN_valid rises exactly ALU_WAIT edges after the acceptance edge.
- RESP:
  - rsp_valid, result and zero are held stable until rspN_ready is high at an edge.
  - At that edge rsp_valid clears and state goes to IDLE.
  - rsp_ready while rsp_valid is low has no effect.
- Throughput: one IDLE cycle between transactions. Best case is one operation per ALU_WAIT+2 cycles.
- The non-owner's rsp regs are untouched by the transaction.
- alu_* keep their last values after the transaction; they are not zeroed.
- A requester may drop valid before acceptance with no effect.
- Changes to req operands after acceptance do not affect the transaction in flight.
- Simultaneous events:
  - Both requesters valid in IDLE resolve by pointer.
  - Requests raised during EXEC or RESP wait; no request is lost while valid is held.
- Reset mid-operation aborts the transaction, drops any pending response, and returns the pointer to requester 0.
- Width: result and zero are passed through verbatim; this block does no arithmetic.

Test Plan:
- The bench uses the ALU with ALU_Sel 000 = ADD.
- Reset then single request: req0 A=1, B=1, sel=000, rsp0_ready=1, ALU_WAIT=1 -> rsp0_valid one edge after accept, rsp0_result=0x02, rsp0_zero=0, busy high for 2 cycles.
- Wrap and Zero: req1 A=0xFF, B=0x01, sel=000 -> rsp1_result=0x00, rsp1_zero=1; rsp0 regs unchanged.
- Contention: both valid continuously from reset, req0 A=1,B=0 and req1 A=2,B=2 -> grants alternate 0,1,0,1; results alternate 0x01 and 0x04; neither starves.
- Backpressure: rsp0_ready held low 5 cycles -> rsp0_valid and rsp0_result stay constant; req1_ready stays 0 throughout; both release after rsp0_ready=1.
- ALU_WAIT=4: req0 A=3, B=4 -> alu_* stable for 4 cycles, rsp0_valid exactly 4 edges after accept, result 0x07.
- Reset in EXEC: assert rst_n=0 mid-wait -> immediately busy=0, rsp*_valid=0, alu_* are 0; the next request is served normally with requester 0 priority.

Source files
------------

// File: rtl/alu_req_arbiter.sv
// ============================================================================
// Module   : alu_req_arbiter
// Brief    : Round-robin arbiter that time-shares one combinational ALU
//            between two valid/ready requesters and returns captured results.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module alu_req_arbiter #(
  parameter int DATA_W   = 8,
  parameter int SEL_W    = 3,
  parameter int ALU_WAIT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  // requester 0
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic [SEL_W-1:0]  req0_sel,
  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  output logic [DATA_W-1:0] rsp0_result,
  output logic              rsp0_zero,
  // requester 1
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic [SEL_W-1:0]  req1_sel,
  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic [DATA_W-1:0] rsp1_result,
  output logic              rsp1_zero,
  // shared ALU
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [SEL_W-1:0]  alu_sel,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_zero,
  output logic              busy
);

  localparam int                 c_CNT_W     = 4;
  localparam logic [c_CNT_W-1:0] c_WAIT_LOAD = c_CNT_W'(ALU_WAIT - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_next_state;
  logic               r_ptr;    // requester that wins a tie
  logic               r_owner;  // requester whose operation is in flight
  logic [c_CNT_W-1:0] r_cnt;

  logic w_grant0;
  logic w_grant1;
  logic w_accept;
  logic w_capture;
  logic w_release;

  // A lone requester always wins; a tie goes to the pointer.
  assign w_grant0 = req0_valid && (!req1_valid || !r_ptr);
  assign w_grant1 = req1_valid && (!req0_valid ||  r_ptr);

  assign req0_ready = (r_state == ST_IDLE) && w_grant0;
  assign req1_ready = (r_state == ST_IDLE) && w_grant1;
  assign busy       = (r_state != ST_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    w_capture    = 1'b0;
    w_release    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (req0_valid || req1_valid) begin
          w_accept     = 1'b1;
          w_next_state = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (r_cnt == '0) begin
          w_capture    = 1'b1;
          w_next_state = ST_RESP;
        end
      end
      ST_RESP: begin
        if (r_owner ? rsp1_ready : rsp0_ready) begin
          w_release    = 1'b1;
          w_next_state = ST_IDLE;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr       <= 1'b0;
      r_owner     <= 1'b0;
      r_cnt       <= '0;
      alu_a       <= '0;
      alu_b       <= '0;
      alu_sel     <= '0;
      rsp0_valid  <= 1'b0;
      rsp0_result <= '0;
      rsp0_zero   <= 1'b0;
      rsp1_valid  <= 1'b0;
      rsp1_result <= '0;
      rsp1_zero   <= 1'b0;
    end else begin
      if (w_accept) begin
        alu_a   <= w_grant1 ? req1_a   : req0_a;
        alu_b   <= w_grant1 ? req1_b   : req0_b;
        alu_sel <= w_grant1 ? req1_sel : req0_sel;
        r_owner <= w_grant1;
        r_ptr   <= ~w_grant1;
        r_cnt   <= c_WAIT_LOAD;
      end

      if ((r_state == ST_EXEC) && !w_capture) begin
        r_cnt <= r_cnt - 1'b1;
      end

      // Only the owner's response registers are ever written.
      if (w_capture) begin
        if (r_owner) begin
          rsp1_result <= alu_result;
          rsp1_zero   <= alu_zero;
          rsp1_valid  <= 1'b1;
        end else begin
          rsp0_result <= alu_result;
          rsp0_zero   <= alu_zero;
          rsp0_valid  <= 1'b1;
        end
      end

      if (w_release) begin
        if (r_owner) begin
          rsp1_valid <= 1'b0;
        end else begin
          rsp0_valid <= 1'b0;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_alu_req_arbiter.sv
// ============================================================================
// Module   : tb_alu_req_arbiter
// Brief    : Self-checking bench: directed vector table, hand sequences and
//            randomized traffic against a rule-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_alu_req_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Index [d] selects the instance (0: ALU_WAIT=1, 1: ALU_WAIT=4), [n] the requester.
  logic       rst_n      [2];
  logic       req_valid  [2][2];
  logic       req_ready  [2][2];
  logic [7:0] req_a      [2][2];
  logic [7:0] req_b      [2][2];
  logic [2:0] req_sel    [2][2];
  logic       rsp_valid  [2][2];
  logic       rsp_ready  [2][2];
  logic [7:0] rsp_result [2][2];
  logic       rsp_zero   [2][2];
  logic [7:0] alu_a      [2];
  logic [7:0] alu_b      [2];
  logic [2:0] alu_sel    [2];
  logic [7:0] alu_result [2];
  logic       alu_zero   [2];
  logic       busy       [2];

  int checks   = 0;
  int failures = 0;

  // Expected architectural state of each instance.
  logic [7:0] exp_res   [2][2];
  logic       exp_zero  [2][2];
  logic [7:0] exp_alu_a [2];
  logic [7:0] exp_alu_b [2];
  logic [2:0] exp_alu_s [2];

  function automatic logic [7:0] alu_f(input logic [7:0] a, input logic [7:0] b, input logic [2:0] s);
    case (s)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a & b;
      3'd3:    return a | b;
      3'd4:    return a ^ b;
      3'd5:    return ~a;
      3'd6:    return a << 1;
      default: return a >> 1;
    endcase
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    assign alu_result[g] = alu_f(alu_a[g], alu_b[g], alu_sel[g]);
    assign alu_zero[g]   = (alu_result[g] == 8'h00);

    alu_req_arbiter #(
      .DATA_W  (8),
      .SEL_W   (3),
      .ALU_WAIT((g == 0) ? 1 : 4)
    ) u_dut (
      .clk        (clk),
      .rst_n      (rst_n[g]),
      .req0_valid (req_valid[g][0]),
      .req0_ready (req_ready[g][0]),
      .req0_a     (req_a[g][0]),
      .req0_b     (req_b[g][0]),
      .req0_sel   (req_sel[g][0]),
      .rsp0_valid (rsp_valid[g][0]),
      .rsp0_ready (rsp_ready[g][0]),
      .rsp0_result(rsp_result[g][0]),
      .rsp0_zero  (rsp_zero[g][0]),
      .req1_valid (req_valid[g][1]),
      .req1_ready (req_ready[g][1]),
      .req1_a     (req_a[g][1]),
      .req1_b     (req_b[g][1]),
      .req1_sel   (req_sel[g][1]),
      .rsp1_valid (rsp_valid[g][1]),
      .rsp1_ready (rsp_ready[g][1]),
      .rsp1_result(rsp_result[g][1]),
      .rsp1_zero  (rsp_zero[g][1]),
      .alu_a      (alu_a[g]),
      .alu_b      (alu_b[g]),
      .alu_sel    (alu_sel[g]),
      .alu_result (alu_result[g]),
      .alu_zero   (alu_zero[g]),
      .busy       (busy[g])
    );
  end

  typedef struct {
    logic       v0;
    logic [7:0] a0;
    logic [7:0] b0;
    logic [2:0] s0;
    logic       v1;
    logic [7:0] a1;
    logic [7:0] b1;
    logic [2:0] s1;
    int         owner;
    logic [7:0] res;
    logic       zero;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic clear_model(input int d);
    for (int n = 0; n < 2; n++) begin
      exp_res[d][n]  = 8'h00;
      exp_zero[d][n] = 1'b0;
    end
    exp_alu_a[d] = 8'h00;
    exp_alu_b[d] = 8'h00;
    exp_alu_s[d] = 3'd0;
  endtask

  task automatic chk_rsp_regs(input int d, input string nm);
    for (int n = 0; n < 2; n++) begin
      chk($sformatf("%s rsp%0d_result", nm, n), 32'(rsp_result[d][n]), 32'(exp_res[d][n]));
      chk($sformatf("%s rsp%0d_zero", nm, n), 32'(rsp_zero[d][n]), 32'(exp_zero[d][n]));
    end
  endtask

  task automatic chk_alu(input int d, input string nm);
    chk({nm, " alu_a"}, 32'(alu_a[d]), 32'(exp_alu_a[d]));
    chk({nm, " alu_b"}, 32'(alu_b[d]), 32'(exp_alu_b[d]));
    chk({nm, " alu_sel"}, 32'(alu_sel[d]), 32'(exp_alu_s[d]));
  endtask

  // Leaves the bench 1 time unit after a rising edge with the instance idle.
  task automatic do_reset(input int d);
    rst_n[d] = 1'b0;
    for (int n = 0; n < 2; n++) begin
      req_valid[d][n] = 1'b0;
      req_a[d][n]     = 8'h00;
      req_b[d][n]     = 8'h00;
      req_sel[d][n]   = 3'd0;
      rsp_ready[d][n] = 1'b0;
    end
    clear_model(d);
    repeat (2) @(posedge clk);
    #1;
    chk($sformatf("reset%0d busy", d), 32'(busy[d]), 32'd0);
    chk($sformatf("reset%0d rsp0_valid", d), 32'(rsp_valid[d][0]), 32'd0);
    chk($sformatf("reset%0d rsp1_valid", d), 32'(rsp_valid[d][1]), 32'd0);
    chk_rsp_regs(d, $sformatf("reset%0d", d));
    chk_alu(d, $sformatf("reset%0d", d));
    @(negedge clk);
    rst_n[d] = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // One full transaction with both response readies held high.
  task automatic txn(input int d, input int w, input vec_t v, input string nm);
    int         n;
    int         k;
    logic [7:0] ea;
    logic [7:0] eb;
    logic [2:0] es;
    req_valid[d][0] = v.v0; req_a[d][0] = v.a0; req_b[d][0] = v.b0; req_sel[d][0] = v.s0;
    req_valid[d][1] = v.v1; req_a[d][1] = v.a1; req_b[d][1] = v.b1; req_sel[d][1] = v.s1;
    rsp_ready[d][0] = 1'b1;
    rsp_ready[d][1] = 1'b1;
    #1;
    chk({nm, " one ready"}, 32'(req_ready[d][0] && req_ready[d][1]), 32'd0);
    n = req_ready[d][1] ? 1 : (req_ready[d][0] ? 0 : 2);
    chk({nm, " grant"}, 32'(n), 32'(v.owner));
    if (n == 2) begin
      req_valid[d][0] = 1'b0;
      req_valid[d][1] = 1'b0;
      return;
    end
    ea = (n == 1) ? v.a1 : v.a0;
    eb = (n == 1) ? v.b1 : v.b0;
    es = (n == 1) ? v.s1 : v.s0;
    @(posedge clk);
    #1;
    req_valid[d][n] = 1'b0;
    exp_alu_a[d] = ea;
    exp_alu_b[d] = eb;
    exp_alu_s[d] = es;
    for (k = 0; k < w; k++) begin
      chk($sformatf("%s wait%0d rsp_valid", nm, k), 32'(rsp_valid[d][n]), 32'd0);
      chk($sformatf("%s wait%0d busy", nm, k), 32'(busy[d]), 32'd1);
      chk_alu(d, $sformatf("%s wait%0d", nm, k));
      @(posedge clk);
      #1;
    end
    exp_res[d][n]  = v.res;
    exp_zero[d][n] = v.zero;
    chk({nm, " rsp_valid"}, 32'(rsp_valid[d][n]), 32'd1);
    chk({nm, " busy in resp"}, 32'(busy[d]), 32'd1);
    chk_rsp_regs(d, nm);
    @(posedge clk);
    #1;
    chk({nm, " rsp_valid cleared"}, 32'(rsp_valid[d][n]), 32'd0);
    chk({nm, " busy cleared"}, 32'(busy[d]), 32'd0);
    chk_alu(d, {nm, " hold"});
  endtask

  // Randomized traffic checked against rule-level expectations.
  task automatic run_random(input int d, input int w, input int ncyc);
    int   cyc       = 0;
    int   in_flight = 0;
    int   in_resp   = 0;
    int   owner     = 0;
    int   acc_cyc   = 0;
    int   ptr       = 0;
    int   acc_n     = -1;
    int   g;
    int   rel       = 0;
    logic ev [2];
    ev[0] = 1'b0;
    ev[1] = 1'b0;
    for (int c = 0; c < ncyc; c++) begin
      @(posedge clk);
      #1;
      cyc++;
      if (rel != 0) begin
        ev[owner] = 1'b0;
        in_flight = 0;
        in_resp   = 0;
      end
      if (acc_n >= 0) begin
        in_flight    = 1;
        owner        = acc_n;
        acc_cyc      = cyc;
        ptr          = 1 - acc_n;
        exp_alu_a[d] = req_a[d][acc_n];
        exp_alu_b[d] = req_b[d][acc_n];
        exp_alu_s[d] = req_sel[d][acc_n];
      end else if (in_flight != 0 && in_resp == 0 && (cyc - acc_cyc) == w) begin
        in_resp          = 1;
        ev[owner]        = 1'b1;
        exp_res[d][owner]  = alu_f(exp_alu_a[d], exp_alu_b[d], exp_alu_s[d]);
        exp_zero[d][owner] = (exp_res[d][owner] == 8'h00);
      end
      chk("rand busy", 32'(busy[d]), 32'(in_flight != 0));
      chk("rand rsp0_valid", 32'(rsp_valid[d][0]), 32'(ev[0]));
      chk("rand rsp1_valid", 32'(rsp_valid[d][1]), 32'(ev[1]));
      chk_rsp_regs(d, "rand");
      chk_alu(d, "rand");

      for (int n = 0; n < 2; n++) begin
        rsp_ready[d][n] = ($urandom_range(0, 2) != 0);
        if (acc_n == n || !req_valid[d][n]) begin
          req_valid[d][n] = ($urandom_range(0, 1) == 1);
          req_a[d][n]     = 8'($urandom_range(0, 255));
          req_b[d][n]     = 8'($urandom_range(0, 255));
          req_sel[d][n]   = 3'($urandom_range(0, 7));
        end else if ($urandom_range(0, 7) == 0) begin
          req_valid[d][n] = 1'b0;
        end
      end
      #1;
      g = -1;
      if (in_flight == 0) begin
        if (req_valid[d][0] && req_valid[d][1]) g = ptr;
        else if (req_valid[d][0])               g = 0;
        else if (req_valid[d][1])               g = 1;
      end
      chk("rand req0_ready", 32'(req_ready[d][0]), 32'(g == 0));
      chk("rand req1_ready", 32'(req_ready[d][1]), 32'(g == 1));
      acc_n = g;
      rel   = (in_resp != 0 && rsp_ready[d][owner]) ? 1 : 0;
    end
    for (int n = 0; n < 2; n++) begin
      req_valid[d][n] = 1'b0;
      rsp_ready[d][n] = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl [8];
    vec_t v;
    tbl[0] = '{1'b1, 8'h01, 8'h01, 3'd0, 1'b0, 8'h00, 8'h00, 3'd0, 0, 8'h02, 1'b0};
    tbl[1] = '{1'b0, 8'h00, 8'h00, 3'd0, 1'b1, 8'hFF, 8'h01, 3'd0, 1, 8'h00, 1'b1};
    tbl[2] = '{1'b1, 8'h01, 8'h00, 3'd0, 1'b1, 8'h02, 8'h02, 3'd0, 0, 8'h01, 1'b0};
    tbl[3] = '{1'b1, 8'h01, 8'h00, 3'd0, 1'b1, 8'h02, 8'h02, 3'd0, 1, 8'h04, 1'b0};
    tbl[4] = '{1'b1, 8'h01, 8'h00, 3'd0, 1'b1, 8'h02, 8'h02, 3'd0, 0, 8'h01, 1'b0};
    tbl[5] = '{1'b1, 8'h01, 8'h00, 3'd0, 1'b1, 8'h02, 8'h02, 3'd0, 1, 8'h04, 1'b0};
    tbl[6] = '{1'b1, 8'hF0, 8'h3C, 3'd2, 1'b1, 8'h02, 8'h02, 3'd0, 0, 8'h30, 1'b0};
    tbl[7] = '{1'b1, 8'h80, 8'h80, 3'd0, 1'b0, 8'h00, 8'h00, 3'd0, 0, 8'h00, 1'b1};

    do_reset(1);
    do_reset(0);
    for (int i = 0; i < 8; i++) begin
      txn(0, 1, tbl[i], $sformatf("vec%0d", i));
    end

    // Backpressure: rsp0 held off while requester 1 waits.
    req_valid[0][0] = 1'b1; req_a[0][0] = 8'h07; req_b[0][0] = 8'h08; req_sel[0][0] = 3'd0;
    req_valid[0][1] = 1'b0;
    rsp_ready[0][0] = 1'b0;
    rsp_ready[0][1] = 1'b1;
    #1;
    chk("bp req0_ready", 32'(req_ready[0][0]), 32'd1);
    @(posedge clk);
    #1;
    req_valid[0][0] = 1'b0;
    req_valid[0][1] = 1'b1; req_a[0][1] = 8'h10; req_b[0][1] = 8'h20; req_sel[0][1] = 3'd0;
    @(posedge clk);
    #1;
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("bp%0d rsp0_valid", k), 32'(rsp_valid[0][0]), 32'd1);
      chk($sformatf("bp%0d rsp0_result", k), 32'(rsp_result[0][0]), 32'h0F);
      chk($sformatf("bp%0d req1_ready", k), 32'(req_ready[0][1]), 32'd0);
      chk($sformatf("bp%0d busy", k), 32'(busy[0]), 32'd1);
      @(posedge clk);
      #1;
    end
    rsp_ready[0][0] = 1'b1;
    @(posedge clk);
    #1;
    exp_res[0][0]  = 8'h0F;
    exp_zero[0][0] = 1'b0;
    chk("bp release rsp0_valid", 32'(rsp_valid[0][0]), 32'd0);
    chk("bp release req1_ready", 32'(req_ready[0][1]), 32'd1);
    @(posedge clk);
    #1;
    req_valid[0][1] = 1'b0;
    @(posedge clk);
    #1;
    exp_res[0][1]  = 8'h30;
    exp_zero[0][1] = 1'b0;
    chk("bp rsp1_valid", 32'(rsp_valid[0][1]), 32'd1);
    chk_rsp_regs(0, "bp");
    @(posedge clk);
    #1;
    chk("bp rsp1_valid cleared", 32'(rsp_valid[0][1]), 32'd0);

    // Longer settle time.
    v = '{1'b1, 8'h03, 8'h04, 3'd0, 1'b0, 8'h00, 8'h00, 3'd0, 0, 8'h07, 1'b0};
    txn(1, 4, v, "wait4");

    // Reset while the operation is still settling.
    req_valid[1][0] = 1'b1; req_a[1][0] = 8'h09; req_b[1][0] = 8'h09; req_sel[1][0] = 3'd0;
    @(posedge clk);
    #1;
    req_valid[1][0] = 1'b0;
    @(posedge clk);
    #1;
    chk("midrst busy before", 32'(busy[1]), 32'd1);
    rst_n[1] = 1'b0;
    #1;
    clear_model(1);
    chk("midrst busy", 32'(busy[1]), 32'd0);
    chk("midrst rsp0_valid", 32'(rsp_valid[1][0]), 32'd0);
    chk("midrst rsp1_valid", 32'(rsp_valid[1][1]), 32'd0);
    chk_alu(1, "midrst");
    chk_rsp_regs(1, "midrst");
    @(negedge clk);
    rst_n[1] = 1'b1;
    @(posedge clk);
    #1;
    v = '{1'b1, 8'h05, 8'h06, 3'd0, 1'b1, 8'h01, 8'h01, 3'd0, 0, 8'h0B, 1'b0};
    txn(1, 4, v, "after rst");

    do_reset(0);
    run_random(0, 1, 300);
    do_reset(1);
    run_random(1, 4, 300);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
